display_scan_driver: RTL
========================

// Module: display_scan_driver
// PURPOSE
//  Final stage between clock time/mode logic and the 4-digit 7-segment pins.
//  Takes four BCD digits, a per-digit blink mask and a colon-dot enable, and
//  time-multiplexes them onto shared segment lines with one-hot digit enables.
//  Digit values are snapshotted once per frame, so a frame never shows mixed time.
// PARAMETERS
//  SCAN_DIV   32     clock cycles each digit is driven (>=2)
//  BLINK_DIV  16384  clock cycles per blink half-period (>=2)
// PORTS
//  i_Clock         in   1  system clock, single domain
//  i_Reset         in   1  synchronous reset, active-high
//  i_Digit0        in   4  BCD, rightmost digit (minutes units)
//  i_Digit1        in   4  BCD, minutes tens
//  i_Digit2        in   4  BCD, hours units (carries colon dot)
//  i_Digit3        in   4  BCD, leftmost digit (hours tens)
//  i_Blink_Mask    in   4  bit k=1: digit k blinks; sampled live every cycle
//  i_Dot_En        in   1  colon dot on digit 2 when 1 (blinks with phase)
//  i_Lz_Blank      in   1  blank digit 3 when its snapshot value is 0; live
//  o_Segments      out  8  {dp,g,f,e,d,c,b,a}, active-high
//  o_Digits        out  4  one-hot active-high digit enable
//  o_Blink_Phase   out  1  current blink phase (1 = "off" half)
//  o_Scan_Tick     out  1  1-cycle pulse when the scan index advances
// BEHAVIOUR
//  Reset (sync, i_Reset=1 at posedge): scan_cnt=0, idx=0, blink_cnt=0,
//   phase=0, snapshot digits=0, snapshot dot=0; o_Segments=0, o_Digits=0000,
//   o_Blink_Phase=0, o_Scan_Tick=0. Reset mid-frame aborts the frame; no residue.
//  Scan counter: 0..SCAN_DIV-1, wraps. At terminal count: idx<=idx+1 (3->0),
//   o_Scan_Tick=1 for that one cycle (registered, coincides with new idx on outputs).
//  Snapshot: on the terminal count where idx==3 (frame end), load Digit0..3 and
//   i_Dot_En into snapshot regs; new values are displayed from next frame on.
//   Input-to-display latency <= 2 frames (8*SCAN_DIV cycles).
//  Blink counter: free-running 0..BLINK_DIV-1, independent of scan; phase
//   toggles at each terminal count. o_Blink_Phase = phase register.
//  Output regs (1-cycle latency from idx/snapshot/phase/live inputs):
//   o_Digits = 1<<idx unless blanked, then 0000; blanked => o_Segments=0.
//   Blank if (i_Blink_Mask[idx] & phase) or (idx==3 & i_Lz_Blank & snap3==0).
//   Segment map a..g: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F;
//   BCD 10..15 => 40 (dash, g only); never X.
//   dp = (idx==2) & snap_dot & ~phase; dp=0 on all other digits.
//  First cycle after reset release: o_Digits=0001, o_Segments=8'h3F.
//  Simultaneous scan and blink terminal counts: both take effect same cycle.
//  Mask/Lz changes take effect on outputs 1 cycle after being applied.
// TESTING (bench uses SCAN_DIV=4, BLINK_DIV=8)
//  1 Reset, release with digits 1,2,3,4 -> cycle 1: Digits=0001, Seg=3F; first
//    frame shows 0000 (snapshot zero); second frame: 0001/06,0010/5B,0100/4F,1000/66.
//  2 Digit0=5 changed mid-frame -> unchanged until next frame start, then 6D on
//    Digit 0001; o_Scan_Tick pulses exactly every 4 cycles.
//  3 Mask=0011, Dot_En=1, digits 12:34 -> phase 0: all digits on, dp=1 on 0100;
//    phase 1 (toggle every 8 cycles): slots 0,1 give Digits=0000 Seg=00, dp=0.
//  4 Digit3=0, Lz_Blank=1 -> slot 3 Digits=0000 Seg=00; Lz_Blank=0 -> 1000/3F.
//  5 Digit1=4'hB -> Seg=40 on 0010; no X on any output in any cycle.
//  6 Assert i_Reset at scan slot 2 mid-blink -> next cycle all outputs 0;
//    after release restarts at 0001 with phase 0 and zero snapshot.

Source files
------------

// File: rtl/display_scan_driver.sv
// ---------------------------------------------------------------------------
// display_scan_driver
//   Drives a 4-digit multiplexed 7-segment display. Four BCD digits and the
//   colon-dot enable are snapshotted once per frame (at the end of the slot
//   for digit 3), so a frame never shows a mix of old and new time. Each digit
//   is driven for SCAN_DIV cycles. A free-running blink counter produces a
//   phase used to blank masked digits and the colon dot.
//
// Ports
//   i_Clock        system clock
//   i_Reset        synchronous reset, active-high
//   i_Digit0..3    BCD digits, 0 = rightmost, 3 = leftmost
//   i_Blink_Mask   bit k set: digit k blanks during the "off" blink phase
//   i_Dot_En       colon dot on digit 2 (blinks with phase)
//   i_Lz_Blank     blank digit 3 when its snapshot value is zero
//   o_Segments     {dp,g,f,e,d,c,b,a}, active-high
//   o_Digits       one-hot active-high digit enable
//   o_Blink_Phase  current blink phase (1 = "off" half)
//   o_Scan_Tick    one-cycle pulse aligned with a new digit on the outputs
// ---------------------------------------------------------------------------
module display_scan_driver #(
    parameter int SCAN_DIV  = 32,
    parameter int BLINK_DIV = 16384
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [3:0] i_Digit0,
    input  logic [3:0] i_Digit1,
    input  logic [3:0] i_Digit2,
    input  logic [3:0] i_Digit3,
    input  logic [3:0] i_Blink_Mask,
    input  logic       i_Dot_En,
    input  logic       i_Lz_Blank,
    output logic [7:0] o_Segments,
    output logic [3:0] o_Digits,
    output logic       o_Blink_Phase,
    output logic       o_Scan_Tick
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    idx;
    logic          phase;
    logic          tick_q;
    logic [3:0]    snap0, snap1, snap2, snap3;
    logic          snap_dot;

    logic          scan_last;
    logic          blink_last;
    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg;
    logic          blank;
    logic          dp;
    logic [7:0]    seg_next;
    logic [3:0]    dig_next;

    assign scan_last  = (scan_cnt  == SW'(SCAN_DIV - 1));
    assign blink_last = (blink_cnt == BW'(BLINK_DIV - 1));

    always_comb begin
        cur_digit = '0;
        case (idx)
            2'd0: cur_digit = snap0;
            2'd1: cur_digit = snap1;
            2'd2: cur_digit = snap2;
            2'd3: cur_digit = snap3;
            default: cur_digit = '0;
        endcase
    end

    // Segment order {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    always_comb begin
        cur_seg = 7'h40;
        case (cur_digit)
            4'd0: cur_seg = 7'h3F;
            4'd1: cur_seg = 7'h06;
            4'd2: cur_seg = 7'h5B;
            4'd3: cur_seg = 7'h4F;
            4'd4: cur_seg = 7'h66;
            4'd5: cur_seg = 7'h6D;
            4'd6: cur_seg = 7'h7D;
            4'd7: cur_seg = 7'h07;
            4'd8: cur_seg = 7'h7F;
            4'd9: cur_seg = 7'h6F;
            default: cur_seg = 7'h40;
        endcase
    end

    always_comb begin
        blank    = (i_Blink_Mask[idx] & phase) |
                   ((idx == 2'd3) & i_Lz_Blank & (snap3 == 4'd0));
        dp       = (idx == 2'd2) & snap_dot & ~phase;
        seg_next = '0;
        dig_next = '0;
        if (!blank) begin
            seg_next = {dp, cur_seg};
            dig_next = 4'b0001 << idx;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            scan_cnt   <= '0;
            idx        <= '0;
            tick_q     <= 1'b0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            snap0      <= '0;
            snap1      <= '0;
            snap2      <= '0;
            snap3      <= '0;
            snap_dot   <= 1'b0;
            o_Segments <= '0;
            o_Digits   <= '0;
            o_Scan_Tick <= 1'b0;
        end else begin
            scan_cnt <= scan_last ? '0 : scan_cnt + SW'(1);
            if (scan_last) begin
                idx <= idx + 2'd1;
                // Frame end: the new snapshot lines up with idx wrapping to 0.
                if (idx == 2'd3) begin
                    snap0    <= i_Digit0;
                    snap1    <= i_Digit1;
                    snap2    <= i_Digit2;
                    snap3    <= i_Digit3;
                    snap_dot <= i_Dot_En;
                end
            end

            blink_cnt <= blink_last ? '0 : blink_cnt + BW'(1);
            if (blink_last) begin
                phase <= ~phase;
            end

            // Tick is delayed one stage so it meets the new digit at the pins.
            tick_q      <= scan_last;
            o_Scan_Tick <= tick_q;
            o_Segments  <= seg_next;
            o_Digits    <= dig_next;
        end
    end

    assign o_Blink_Phase = phase;

endmodule
